mem_wb_stage: RTL and testbench



---
 rtl/mem_wb_pkg.sv | 21 ++
 rtl/memwb_reg.sv | 33 +++
 rtl/mem_wb_stage.sv | 152 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared types for the MEM stage and MEM/WB register.
// Holds FSM state enum, default widths and the MEM/WB bundle.
package mem_wb_pkg;

   localparam int PKG_DATA_W  = 32;
   localparam int PKG_RADDR_W = 5;

   typedef enum logic {
      IDLE,
      WAIT
   } state_e;

   typedef struct packed {
      logic                   memtoreg;
      logic                   regwrite;
      logic [PKG_DATA_W-1:0]  alu;
      logic [PKG_DATA_W-1:0]  rdata;
      logic [PKG_RADDR_W-1:0] rd_addr;
   } memwb_t;

endpackage

// File: rtl/memwb_reg.sv
// memwb_reg: MEM/WB pipeline register with bubble and load control.
// Ports: clk_i, rst_i, bubble_i, rdata_en_i, d_i (next), q_o (held).
module memwb_reg
   import mem_wb_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   bubble_i,
   input  logic   rdata_en_i,
   input  memwb_t d_i,
   output memwb_t q_o
);

   // A bubble kills only the control bits; data fields keep their
   // last value so write-back sees stable (but unused) operands.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_o <= '0;
      end else if (bubble_i) begin
         q_o.regwrite <= 1'b0;
         q_o.memtoreg <= 1'b0;
      end else begin
         q_o.memtoreg <= d_i.memtoreg;
         q_o.regwrite <= d_i.regwrite;
         q_o.alu      <= d_i.alu;
         q_o.rd_addr  <= d_i.rd_addr;
         if (rdata_en_i) begin
            q_o.rdata <= d_i.rdata;
         end
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage with dmem req/ack, stall, PCSrc, MEM/WB reg.
// In: EX/MEM controls, alu_i, rt_i, rd_addr_i, dmem ack/rdata.
// Out: dmem req/we/addr/wdata, stall_o, pcsrc_o, err_o, MEM/WB fields.
// Optional MEM_TIMEOUT_EN: abort a WAIT after TIMEOUT_CYC cycles.
module mem_wb_stage
   import mem_wb_pkg::*;
#(
   parameter int DATA_W      = PKG_DATA_W,
   parameter int RADDR_W     = PKG_RADDR_W,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               memread_i,
   input  logic               memwrite_i,
   input  logic               branch_i,
   input  logic               zero_i,
   input  logic               memtoreg_i,
   input  logic               regwrite_i,
   input  logic [DATA_W-1:0]  alu_i,
   input  logic [DATA_W-1:0]  rt_i,
   input  logic [RADDR_W-1:0] rd_addr_i,
   output logic               dmem_req_o,
   output logic               dmem_we_o,
   output logic [DATA_W-1:0]  dmem_addr_o,
   output logic [DATA_W-1:0]  dmem_wdata_o,
   input  logic               dmem_ack_i,
   input  logic [DATA_W-1:0]  dmem_rdata_i,
   output logic               stall_o,
   output logic               pcsrc_o,
   output logic               err_o,
   output logic               memtoreg_o,
   output logic               regwrite_o,
   output logic [DATA_W-1:0]  alu_o,
   output logic [DATA_W-1:0]  rdata_o,
   output logic [RADDR_W-1:0] rd_addr_o
);

   state_e state_q;
   state_e state_d;
   logic   access;
   logic   ack_v;
   logic   abort;
   logic   stall;
   logic   rd_load;
   memwb_t wb_d;
   memwb_t wb_q;

   assign access = memread_i | memwrite_i;
   // An ack without an access is stray and must not move the FSM.
   assign ack_v  = access & dmem_ack_i;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (state_q == WAIT) begin
         if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else begin
         cnt_q <= '0;
      end
   end

   assign abort = (state_q == WAIT) && (cnt_q == CNT_MAX);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (abort) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   logic unused_tmo;
   assign unused_tmo = |TIMEOUT_CYC;
   assign abort      = 1'b0;
   assign err_o      = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (access && !dmem_ack_i) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (ack_v || abort || !access) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign stall = access & ~dmem_ack_i & ~abort & ~rst_i;

   assign stall_o      = stall;
   assign dmem_req_o   = access & ~abort & ~rst_i;
   assign dmem_we_o    = memwrite_i;
   assign dmem_addr_o  = alu_i;
   assign dmem_wdata_o = rt_i;
   // Branches never touch memory, so no stall gating is needed.
   assign pcsrc_o      = branch_i & zero_i;

   // Read+write together is a store: load data is not captured.
   assign rd_load = memread_i & ~memwrite_i & dmem_ack_i;

   always_comb begin
      wb_d          = '0;
      wb_d.memtoreg = memtoreg_i;
      wb_d.regwrite = regwrite_i;
      wb_d.alu      = alu_i;
      wb_d.rdata    = dmem_rdata_i;
      wb_d.rd_addr  = rd_addr_i;
   end

   memwb_reg u_memwb_reg (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .bubble_i   (stall | abort),
      .rdata_en_i (rd_load),
      .d_i        (wb_d),
      .q_o        (wb_q)
   );

   assign memtoreg_o = wb_q.memtoreg;
   assign regwrite_o = wb_q.regwrite;
   assign alu_o      = wb_q.alu;
   assign rdata_o    = wb_q.rdata;
   assign rd_addr_o  = wb_q.rd_addr;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: self-checking bench for mem_wb_stage.
// Directed scenarios plus random transactions vs a write-back model.
module tb_mem_wb_stage;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int TMO = 4;

   logic          clk;
   logic          rst;
   logic          memread, memwrite, branch, zero;
   logic          memtoreg, regwrite;
   logic [DW-1:0] alu, rt, rdata_in;
   logic [AW-1:0] rd_a;
   logic          ack;
   logic          req, we, stall, pcsrc, err;
   logic [DW-1:0] addr, wdata;
   logic          mtr_o, rw_o;
   logic [DW-1:0] alu_o, rdata_o;
   logic [AW-1:0] rd_o;

   int vectors;
   int miscompares;

   // Write-back model: what the MEM/WB register should hold.
   logic          m_rw, m_mtr, m_err;
   logic [DW-1:0] m_alu, m_rdata;
   logic [AW-1:0] m_rd;

   mem_wb_stage #(
      .DATA_W      (DW),
      .RADDR_W     (AW),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .memread_i    (memread),
      .memwrite_i   (memwrite),
      .branch_i     (branch),
      .zero_i       (zero),
      .memtoreg_i   (memtoreg),
      .regwrite_i   (regwrite),
      .alu_i        (alu),
      .rt_i         (rt),
      .rd_addr_i    (rd_a),
      .dmem_req_o   (req),
      .dmem_we_o    (we),
      .dmem_addr_o  (addr),
      .dmem_wdata_o (wdata),
      .dmem_ack_i   (ack),
      .dmem_rdata_i (rdata_in),
      .stall_o      (stall),
      .pcsrc_o      (pcsrc),
      .err_o        (err),
      .memtoreg_o   (mtr_o),
      .regwrite_o   (rw_o),
      .alu_o        (alu_o),
      .rdata_o      (rdata_o),
      .rd_addr_o    (rd_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle_inputs();
      memread  = 1'b0;
      memwrite = 1'b0;
      branch   = 1'b0;
      zero     = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      alu      = '0;
      rt       = '0;
      rd_a     = '0;
      ack      = 1'b0;
      rdata_in = '0;
   endtask

   task automatic model_clear();
      m_rw    = 1'b0;
      m_mtr   = 1'b0;
      m_err   = 1'b0;
      m_alu   = '0;
      m_rdata = '0;
      m_rd    = '0;
   endtask

   // Expected write-back after a non-stalled edge.
   task automatic model_commit();
      m_rw  = regwrite;
      m_mtr = memtoreg;
      m_alu = alu;
      m_rd  = rd_a;
      if (memread && !memwrite && ack) m_rdata = rdata_in;
   endtask

   task automatic model_bubble();
      m_rw  = 1'b0;
      m_mtr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (req !== 1'b0 || stall !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_comb: req=%b stall=%b err=%b want 0",
                  req, stall, err);
      end
      vectors++;
      if ({mtr_o, rw_o, alu_o, rdata_o, rd_o} !== '0) begin
         miscompares++;
         $display("FAIL reset_wb: rw=%b mtr=%b alu=%h rdata=%h rd=%h want 0",
                  rw_o, mtr_o, alu_o, rdata_o, rd_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_zero_wait_load();
      memread  = 1'b1;
      alu      = 32'h40;
      ack      = 1'b1;
      rdata_in = 32'hDEADBEEF;
      regwrite = 1'b1;
      memtoreg = 1'b1;
      rd_a     = 5'd3;
      #3;
      vectors++;
      if (stall !== 1'b0 || req !== 1'b1) begin
         miscompares++;
         $display("FAIL zw_comb: stall=%b req=%b want 0/1", stall, req);
      end
      model_commit();
      @(posedge clk);
      #1;
      vectors++;
      if (rdata_o !== 32'hDEADBEEF || rw_o !== 1'b1 || mtr_o !== 1'b1) begin
         miscompares++;
         $display("FAIL zw_wb: rdata=%h rw=%b mtr=%b want deadbeef/1/1",
                  rdata_o, rw_o, mtr_o);
      end
      idle_inputs();
   endtask

   task automatic test_store3();
      logic [DW-1:0] old_alu;
      old_alu  = m_alu;
      memwrite = 1'b1;
      rt       = 32'h1234;
      alu      = 32'h80;
      for (int c = 1; c <= 3; c++) begin
         ack = (c == 3);
         #3;
         vectors++;
         if (stall !== (c < 3) || we !== 1'b1 || wdata !== 32'h1234) begin
            miscompares++;
            $display("FAIL st3_comb c%0d: stall=%b we=%b wdata=%h want %b/1/1234",
                     c, stall, we, wdata, (c < 3));
         end
         if (c < 3) model_bubble();
         else model_commit();
         @(posedge clk);
         #1;
         vectors++;
         if (rw_o !== 1'b0 || alu_o !== ((c < 3) ? old_alu : 32'h80)) begin
            miscompares++;
            $display("FAIL st3_wb c%0d: rw=%b alu=%h want 0/%h",
                     c, rw_o, alu_o, (c < 3) ? old_alu : 32'h80);
         end
      end
      idle_inputs();
      #3;
      vectors++;
      if (stall !== 1'b0 || req !== 1'b0) begin
         miscompares++;
         $display("FAIL st3_after: stall=%b req=%b want 0/0", stall, req);
      end
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic test_branch();
      for (int z = 1; z >= 0; z--) begin
         branch = 1'b1;
         zero   = z[0];
         #3;
         vectors++;
         if (pcsrc !== z[0] || req !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL branch z%0d: pcsrc=%b req=%b stall=%b want %0d/0/0",
                     z, pcsrc, req, stall, z);
         end
         model_commit();
         @(posedge clk);
         #1;
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      regwrite = 1'b1;
      rd_a     = 5'd1;
      alu      = 32'd5;
      #3;
      vectors++;
      if (stall !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_stall0: stall=%b want 0", stall);
      end
      model_commit();
      @(posedge clk);
      #1;
      vectors++;
      if (alu_o !== 32'd5 || rw_o !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_first: alu=%0d rw=%b want 5/1", alu_o, rw_o);
      end
      alu = 32'd7;
      #3;
      vectors++;
      if (stall !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_stall1: stall=%b want 0", stall);
      end
      model_commit();
      @(posedge clk);
      #1;
      vectors++;
      if (alu_o !== 32'd7 || rw_o !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_second: alu=%0d rw=%b want 7/1", alu_o, rw_o);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      int  kind;
      int  w;
      logic acc;
      for (int n = 0; n < 40; n++) begin
         kind     = $urandom_range(0, 3);
         memread  = (kind == 1) || (kind == 3);
         memwrite = (kind == 2) || (kind == 3);
         acc      = memread | memwrite;
         w        = acc ? $urandom_range(0, 3) : 0;
         branch   = acc ? 1'b0 : 1'($urandom);
         zero     = 1'($urandom);
         memtoreg = 1'($urandom);
         regwrite = 1'($urandom);
         alu      = $urandom;
         rt       = $urandom;
         rd_a     = 5'($urandom);
         for (int c = 0; c <= w; c++) begin
            ack      = acc ? (c == w) : 1'($urandom);
            rdata_in = $urandom;
            #3;
            vectors++;
            if (stall !== (acc && c < w) || req !== acc ||
                pcsrc !== (branch & zero) || we !== memwrite ||
                addr !== alu || wdata !== rt) begin
               miscompares++;
               $display("FAIL rnd_comb n%0d c%0d: stall=%b req=%b pcsrc=%b want %b/%b/%b",
                        n, c, stall, req, pcsrc, (acc && c < w), acc,
                        branch & zero);
            end
            if (acc && c < w) model_bubble();
            else model_commit();
            @(posedge clk);
            #1;
            vectors++;
            if (rw_o !== m_rw || mtr_o !== m_mtr || alu_o !== m_alu ||
                rdata_o !== m_rdata || rd_o !== m_rd || err !== m_err) begin
               miscompares++;
               $display("FAIL rnd_wb n%0d c%0d: rw=%b mtr=%b alu=%h rd=%h rdata=%h err=%b want %b/%b/%h/%h/%h/%b",
                        n, c, rw_o, mtr_o, alu_o, rd_o, rdata_o, err,
                        m_rw, m_mtr, m_alu, m_rd, m_rdata, m_err);
            end
         end
      end
      idle_inputs();
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      int drop;
      drop     = -1;
      memread  = 1'b1;
      regwrite = 1'b1;
      memtoreg = 1'b1;
      alu      = $urandom;
      rd_a     = 5'd9;
      for (int c = 0; c < 12; c++) begin
         #3;
         if (!stall) begin
            drop = c;
            break;
         end
         model_bubble();
         @(posedge clk);
         #1;
      end
      vectors++;
      if (drop != TMO + 1 || req !== 1'b0) begin
         miscompares++;
         $display("FAIL tmo_drop: stall fell at cycle %0d req=%b want %0d/0",
                  drop, req, TMO + 1);
      end
      model_bubble();
      m_err = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (err !== 1'b1 || rw_o !== 1'b0 || alu_o !== m_alu) begin
         miscompares++;
         $display("FAIL tmo_abort: err=%b rw=%b alu=%h want 1/0/%h",
                  err, rw_o, alu_o, m_alu);
      end
      idle_inputs();
      repeat (3) begin
         model_commit();
         @(posedge clk);
         #1;
      end
      vectors++;
      if (err !== 1'b1 || stall !== 1'b0) begin
         miscompares++;
         $display("FAIL tmo_sticky: err=%b stall=%b want 1/0", err, stall);
      end
   endtask
`else
   task automatic test_timeout();
      memread  = 1'b1;
      regwrite = 1'b1;
      memtoreg = 1'b1;
      alu      = $urandom;
      rd_a     = 5'd9;
      for (int c = 0; c < 3 * TMO; c++) begin
         #3;
         vectors++;
         if (stall !== 1'b1 || req !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL notmo_wait c%0d: stall=%b req=%b err=%b want 1/1/0",
                     c, stall, req, err);
         end
         model_bubble();
         @(posedge clk);
         #1;
      end
      ack      = 1'b1;
      rdata_in = 32'hA5A5_0F0F;
      model_commit();
      @(posedge clk);
      #1;
      vectors++;
      if (rdata_o !== 32'hA5A5_0F0F || rw_o !== 1'b1 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL notmo_ack: rdata=%h rw=%b err=%b want a5a50f0f/1/0",
                  rdata_o, rw_o, err);
      end
      idle_inputs();
   endtask
`endif

   task automatic test_reset_mid_wait();
      memread  = 1'b1;
      regwrite = 1'b1;
      memtoreg = 1'b1;
      alu      = 32'h1000;
      rd_a     = 5'd7;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      model_clear();
      #1;
      vectors++;
      if (req !== 1'b0 || stall !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL rstw_comb: req=%b stall=%b err=%b want 0",
                  req, stall, err);
      end
      vectors++;
      if ({mtr_o, rw_o, alu_o, rdata_o, rd_o} !== '0) begin
         miscompares++;
         $display("FAIL rstw_wb: rw=%b alu=%h rdata=%h rd=%h want 0",
                  rw_o, alu_o, rdata_o, rd_o);
      end
      ack      = 1'b1;
      rdata_in = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      memread  = 1'b0;
      regwrite = 1'b0;
      memtoreg = 1'b0;
      #3;
      vectors++;
      if (stall !== 1'b0 || req !== 1'b0) begin
         miscompares++;
         $display("FAIL rstw_late_comb: stall=%b req=%b want 0/0", stall, req);
      end
      model_commit();
      @(posedge clk);
      #1;
      vectors++;
      if (rdata_o !== m_rdata || rw_o !== 1'b0 || mtr_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rstw_late_wb: rdata=%h rw=%b mtr=%b want %h/0/0",
                  rdata_o, rw_o, mtr_o, m_rdata);
      end
      idle_inputs();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_zero_wait_load();
      test_store3();
      test_branch();
      test_back_to_back();
      test_random();
      test_timeout();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
